// File: rtl/plru_tree.sv
// plru_tree -- per-set tree pseudo-LRU replacement state with masked victim query.
//
// Each of SETS sets owns a binary tree of WAYS-1 node bits, heap indexed
// 1..WAYS-1. Node n has child 2n covering the lower-index ways and child 2n+1
// covering the upper-index ways. Node bit 0 means "victim in lower child" and
// 1 means "victim in upper child". Node 1 is the root and splits on the way MSB.
//
// Ports:
//   clk         sole clock, all state changes on the rising edge
//   rst_n       asynchronous active-low reset, clears every tree
//   acc_valid   touch request. There is no ready: a touch is always accepted
//               on the edge where acc_valid=1 (unless flush or reset wins).
//   acc_set     set index of the touch
//   acc_way     way index touched (hit or fill)
//   qry_set     set whose victim is reported
//   valid_mask  per-way valid bits of qry_set (bit i = way i)
//   lock_mask   per-way lock bits of qry_set; locked ways are never chosen
//   flush       clears all trees on the next edge, overriding any touch
//   repl_way    chosen victim way for qry_set (0 when none exists)
//   repl_valid  1 when at least one way of qry_set is unlocked
//
// The query is purely combinational from the registered tree of qry_set, so a
// touch only becomes visible on the cycle after it (no bypass).
module plru_tree #(
  parameter int WAYS = 8,
  parameter int SETS = 16,
  localparam int WAY_W = $clog2(WAYS),
  localparam int SET_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             acc_valid,
  input  logic [SET_W-1:0] acc_set,
  input  logic [WAY_W-1:0] acc_way,
  input  logic [SET_W-1:0] qry_set,
  input  logic [WAYS-1:0]  valid_mask,
  input  logic [WAYS-1:0]  lock_mask,
  input  logic             flush,
  output logic [WAY_W-1:0] repl_way,
  output logic             repl_valid
);

  logic [WAYS-1:1] tree_q [SETS];
  logic [WAYS-1:1] tree_d [SETS];

  // ---------------------------------------------------------------------------
  // Tree update: every node on the touched way's root-to-leaf path is pointed
  // at the sibling of the branch the touched way lives in.
  // ---------------------------------------------------------------------------
  logic [WAY_W-1:0] upd_node;
  logic             upd_bit;

  always_comb begin
    tree_d   = tree_q;
    upd_node = WAY_W'(1);
    upd_bit  = 1'b0;
    if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        tree_d[s] = '0;
      end
    end else if (acc_valid) begin
      for (int l = 0; l < WAY_W; l++) begin
        upd_bit                   = acc_way[WAY_W-1-l];
        tree_d[acc_set][upd_node] = ~upd_bit;
        // The shift drops the top bit after the leaf level; that value is
        // never used as an index.
        upd_node                  = (upd_node << 1) | WAY_W'(upd_bit);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        tree_q[s] <= '0;
      end
    end else begin
      tree_q <= tree_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Victim query.
  // An invalid, unlocked way always wins (lowest index first). Otherwise walk
  // the tree from the root; if the pointed-to child subtree is fully locked,
  // take the other child. Because the current subtree always holds at least
  // one unlocked way, the other child is then guaranteed to have one.
  // ---------------------------------------------------------------------------
  logic [WAYS-1:1]  qry_tree;
  logic             free_found;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] walk_node;
  logic [WAY_W-1:0] walk_way;
  logic             walk_dir;
  logic             sub_locked;
  int               prefix;
  int               target;

  always_comb begin
    qry_tree   = tree_q[qry_set];
    free_found = 1'b0;
    free_way   = '0;
    walk_node  = WAY_W'(1);
    walk_dir   = 1'b0;
    sub_locked = 1'b0;
    prefix     = 0;
    target     = 0;

    // Descending scan so the lowest qualifying index is the last one written.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_mask[w] && !lock_mask[w]) begin
        free_found = 1'b1;
        free_way   = WAY_W'(w);
      end
    end

    // prefix holds the way-index bits chosen so far (MSB first).
    for (int l = 0; l < WAY_W; l++) begin
      walk_dir   = qry_tree[walk_node];
      target     = prefix * 2 + int'(walk_dir);
      sub_locked = 1'b1;
      for (int w = 0; w < WAYS; w++) begin
        if ((w >> (WAY_W - 1 - l)) == target) begin
          sub_locked = sub_locked & lock_mask[w];
        end
      end
      if (sub_locked) begin
        walk_dir = ~walk_dir;
      end
      prefix    = prefix * 2 + int'(walk_dir);
      walk_node = (walk_node << 1) | WAY_W'(walk_dir);
    end
    walk_way = WAY_W'(prefix);
  end

  assign repl_valid = ~(&lock_mask);
  assign repl_way   = !repl_valid ? '0 : (free_found ? free_way : walk_way);

endmodule

// File: tb/tb_plru_tree.sv
// Testbench for plru_tree with WAYS=4, SETS=4.
// The reference model keeps, per set, the history of touches since the last
// reset/flush. A subtree's preferred half is the one opposite the most recent
// touch falling inside that subtree (lower half if it was never touched).
module tb_plru_tree;
  localparam int WAYS  = 4;
  localparam int SETS  = 4;
  localparam int WAY_W = 2;
  localparam int SET_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             acc_valid;
  logic [SET_W-1:0] acc_set;
  logic [WAY_W-1:0] acc_way;
  logic [SET_W-1:0] qry_set;
  logic [WAYS-1:0]  valid_mask;
  logic [WAYS-1:0]  lock_mask;
  logic             flush;
  logic [WAY_W-1:0] repl_way;
  logic             repl_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  int hist [SETS][$];

  plru_tree #(.WAYS(WAYS), .SETS(SETS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .acc_valid  (acc_valid),
    .acc_set    (acc_set),
    .acc_way    (acc_way),
    .qry_set    (qry_set),
    .valid_mask (valid_mask),
    .lock_mask  (lock_mask),
    .flush      (flush),
    .repl_way   (repl_way),
    .repl_valid (repl_valid)
  );

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  function automatic void model_clear();
    for (int s = 0; s < SETS; s++) hist[s].delete();
  endfunction

  // 1 when the most recent touch inside [lo, lo+size) was in the lower half.
  function automatic bit model_pref_upper(int s, int lo, int size);
    for (int i = hist[s].size() - 1; i >= 0; i--) begin
      if (hist[s][i] >= lo && hist[s][i] < lo + size)
        return (hist[s][i] < lo + size / 2);
    end
    return 1'b0;
  endfunction

  function automatic bit model_all_locked(logic [WAYS-1:0] lm, int lo, int size);
    for (int i = lo; i < lo + size; i++) if (!lm[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Returns {valid, way}.
  function automatic logic [WAY_W:0] model_pick(int s, logic [WAYS-1:0] vm, logic [WAYS-1:0] lm);
    int lo, size, half;
    bit up;
    if (lm == '1) return '0;
    for (int i = 0; i < WAYS; i++)
      if (!vm[i] && !lm[i]) return {1'b1, WAY_W'(i)};
    lo = 0;
    size = WAYS;
    while (size > 1) begin
      half = size / 2;
      up = model_pref_upper(s, lo, size);
      if (up && model_all_locked(lm, lo + half, half)) up = 1'b0;
      else if (!up && model_all_locked(lm, lo, half)) up = 1'b1;
      if (up) lo = lo + half;
      size = half;
    end
    return {1'b1, WAY_W'(lo)};
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (flush) model_clear();
      else if (acc_valid) hist[acc_set].push_back(int'(acc_way));
    end
    #1;
  endtask

  task automatic idle_inputs();
    acc_valid  = 1'b0;
    acc_set    = '0;
    acc_way    = '0;
    flush      = 1'b0;
    qry_set    = '0;
    valid_mask = '1;
    lock_mask  = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_clear();
    #1;
    for (int s = 0; s < SETS; s++) begin
      qry_set = SET_W'(s);
      #1;
      n_cmp++;
      if ({repl_valid, repl_way} !== 3'b100) begin
        n_fail++;
        $display("FAIL reset_set%0d: got valid=%0b way=%0d, want valid=1 way=0", s, repl_valid, repl_way);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    int ways [4]    = '{0, 2, 1, 3};
    int expect_w [5] = '{0, 2, 1, 3, 0};
    do_reset();
    qry_set = 0;
    for (int i = 0; i < 4; i++) begin
      acc_valid = 1'b1;
      acc_set   = 0;
      acc_way   = WAY_W'(ways[i]);
      #1;
      // touch pending on the same set: output must still show old state
      n_cmp++;
      if ({repl_valid, repl_way} !== {1'b1, WAY_W'(expect_w[i])}) begin
        n_fail++;
        $display("FAIL seq_step%0d: got valid=%0b way=%0d, want valid=1 way=%0d", i, repl_valid, repl_way, expect_w[i]);
      end
      tick();
    end
    acc_valid = 1'b0;
    #1;
    n_cmp++;
    if ({repl_valid, repl_way} !== {1'b1, WAY_W'(expect_w[4])}) begin
      n_fail++;
      $display("FAIL seq_final: got valid=%0b way=%0d, want valid=1 way=%0d", repl_valid, repl_way, expect_w[4]);
    end
  endtask

  task automatic test_lock();
    logic [WAYS-1:0]  masks [3] = '{4'b0001, 4'b0011, 4'b1111};
    logic [WAY_W:0]   exp_v [3] = '{3'b101, 3'b110, 3'b000};
    do_reset();
    qry_set = 0;
    for (int i = 0; i < 3; i++) begin
      lock_mask = masks[i];
      #1;
      n_cmp++;
      if ({repl_valid, repl_way} !== exp_v[i]) begin
        n_fail++;
        $display("FAIL lock_%b: got valid=%0b way=%0d, want {valid,way}=%b", masks[i], repl_valid, repl_way, exp_v[i]);
      end
    end
    lock_mask = '0;
  endtask

  task automatic test_valid_mask();
    logic [WAY_W:0] expv;
    do_reset();
    qry_set = 0;
    for (int k = 0; k < 6; k++) begin
      acc_valid = 1'b1;
      acc_set   = 0;
      acc_way   = WAY_W'($urandom_range(0, WAYS - 1));
      tick();
      acc_valid = 1'b0;
      valid_mask = 4'b1011;
      lock_mask  = 4'b0000;
      #1;
      n_cmp++;
      if ({repl_valid, repl_way} !== 3'b110) begin
        n_fail++;
        $display("FAIL invalid_way2_k%0d: got valid=%0b way=%0d, want valid=1 way=2", k, repl_valid, repl_way);
      end
      lock_mask = 4'b0100;
      #1;
      expv = model_pick(0, valid_mask, lock_mask);
      n_cmp++;
      if ({repl_valid, repl_way} !== expv || repl_way == 2'd2) begin
        n_fail++;
        $display("FAIL invalid_locked_k%0d: got valid=%0b way=%0d, want {valid,way}=%b", k, repl_valid, repl_way, expv);
      end
      valid_mask = '1;
      lock_mask  = '0;
    end
  endtask

  task automatic test_isolation();
    do_reset();
    acc_valid = 1'b1;
    acc_set   = 1;
    acc_way   = 0;
    tick();
    acc_valid = 1'b0;
    qry_set = 1;
    #1;
    n_cmp++;
    if ({repl_valid, repl_way} !== 3'b110) begin
      n_fail++;
      $display("FAIL iso_set1: got valid=%0b way=%0d, want valid=1 way=2", repl_valid, repl_way);
    end
    qry_set = 0;
    #1;
    n_cmp++;
    if ({repl_valid, repl_way} !== 3'b100) begin
      n_fail++;
      $display("FAIL iso_set0: got valid=%0b way=%0d, want valid=1 way=0", repl_valid, repl_way);
    end
  endtask

  task automatic test_flush();
    do_reset();
    acc_valid = 1'b1;
    acc_set   = 1;
    acc_way   = 1;
    tick();
    acc_set   = 2;
    acc_way   = 0;
    tick();
    qry_set = 2;
    acc_valid = 1'b1;
    acc_set   = 2;
    acc_way   = 2;
    flush     = 1'b1;
    #1;
    n_cmp++;
    if ({repl_valid, repl_way} !== 3'b110) begin
      n_fail++;
      $display("FAIL flush_pre: got valid=%0b way=%0d, want valid=1 way=2", repl_valid, repl_way);
    end
    tick();
    flush     = 1'b0;
    acc_valid = 1'b0;
    for (int s = 1; s <= 2; s++) begin
      qry_set = SET_W'(s);
      #1;
      n_cmp++;
      if ({repl_valid, repl_way} !== 3'b100) begin
        n_fail++;
        $display("FAIL flush_set%0d: got valid=%0b way=%0d, want valid=1 way=0", s, repl_valid, repl_way);
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int s = 0; s < SETS; s++) begin
      acc_valid = 1'b1;
      acc_set   = SET_W'(s);
      acc_way   = WAY_W'($urandom_range(0, WAYS - 1));
      if (s == 0) acc_way = 0;
      tick();
    end
    // acc_valid stays high through the reset pulse; it must be discarded
    #2;
    rst_n = 1'b0;
    model_clear();
    for (int s = 0; s < SETS; s++) begin
      qry_set = SET_W'(s);
      #1;
      n_cmp++;
      if ({repl_valid, repl_way} !== 3'b100) begin
        n_fail++;
        $display("FAIL rst_mid_during_set%0d: got valid=%0b way=%0d, want valid=1 way=0", s, repl_valid, repl_way);
      end
    end
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    acc_valid = 1'b0;
    for (int s = 0; s < SETS; s++) begin
      qry_set = SET_W'(s);
      #1;
      n_cmp++;
      if ({repl_valid, repl_way} !== 3'b100) begin
        n_fail++;
        $display("FAIL rst_mid_after_set%0d: got valid=%0b way=%0d, want valid=1 way=0", s, repl_valid, repl_way);
      end
    end
  endtask

  task automatic test_random();
    logic [WAY_W:0] expv;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      acc_valid = 1'($urandom_range(0, 1));
      acc_set   = SET_W'($urandom_range(0, SETS - 1));
      acc_way   = WAY_W'($urandom_range(0, WAYS - 1));
      flush     = ($urandom_range(0, 24) == 0);
      qry_set   = SET_W'($urandom_range(0, SETS - 1));
      case ($urandom_range(0, 4))
        0, 1:    lock_mask = '0;
        2:       lock_mask = '1;
        default: lock_mask = WAYS'($urandom);
      endcase
      valid_mask = ($urandom_range(0, 1) == 1) ? '1 : WAYS'($urandom);
      #1;
      expv = model_pick(int'(qry_set), valid_mask, lock_mask);
      n_cmp++;
      if ({repl_valid, repl_way} !== expv) begin
        n_fail++;
        $display("FAIL random_%0d set%0d vm=%b lm=%b: got valid=%0b way=%0d, want {valid,way}=%b",
                 i, qry_set, valid_mask, lock_mask, repl_valid, repl_way, expv);
      end
      tick();
    end
    idle_inputs();
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    test_reset();
    test_sequence();
    test_lock();
    test_valid_mask();
    test_isolation();
    test_flush();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
